// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache between the cpu data port and a block-wide data memory.
// Latency: hits take 0 stall cycles. A clean miss takes 1+M+1+1 cycles. A dirty miss adds M+1 cycles for the eviction (M = memory busy cycles).
// Backpressure: BUSYWAIT holds the cpu through a miss. MEM_BUSYWAIT holds the FSM in WRITE_BACK / MEM_READ_ST.
// Ports: CLK/RESET (async, active-high); cpu side READ, WRITE, ADDRESS, WRITEDATA, READDATA, BUSYWAIT;
//        memory side MEM_READ, MEM_WRITE, MEM_ADDRESS {tag,index}, MEM_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT.
module dcache_direct_mapped #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           READ,
  input  logic                           WRITE,
  input  logic [7:0]                     ADDRESS,
  input  logic [7:0]                     WRITEDATA,
  output logic [7:0]                     READDATA,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic                           MEM_WRITE,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  output logic [(8<<OFFSET_BITS)-1:0]    MEM_WRITEDATA,
  input  logic [(8<<OFFSET_BITS)-1:0]    MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
);

  localparam int NBLK = 1 << INDEX_BITS;
  localparam int BW   = 8 << OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BACK  = 2'd1,
    MEM_READ_ST = 2'd2,
    UPDATE      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [BW-1:0]       data_q  [NBLK];
  logic [TAG_BITS-1:0] tag_q   [NBLK];
  logic [NBLK-1:0]     valid_q;
  logic [NBLK-1:0]     dirty_q;
  logic [BW-1:0]       fill_q;

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]    tag_in;
  logic [OFFSET_BITS-1:0] off;
  logic                   hit;
  logic                   do_write;

  assign idx    = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign tag_in = ADDRESS[7 -: TAG_BITS];
  assign off    = ADDRESS[OFFSET_BITS-1:0];
  assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

  // Reset clears every data block, so READDATA reads 0 during and right after reset.
  assign READDATA = data_q[idx][{off, 3'b000} +: 8];

  always_comb begin
    state_nxt     = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    do_write      = 1'b0;
    unique case (state)
      IDLE: begin
        if (READ || WRITE) begin
          if (hit) begin
            // A simultaneous READ and WRITE is handled as a write.
            do_write = WRITE;
          end else begin
            BUSYWAIT  = 1'b1;
            state_nxt = dirty_q[idx] ? WRITE_BACK : MEM_READ_ST;
          end
        end
      end
      WRITE_BACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = data_q[idx];
        if (!MEM_BUSYWAIT) state_nxt = MEM_READ_ST;
      end
      MEM_READ_ST: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag_in, idx};
        if (!MEM_BUSYWAIT) state_nxt = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is held, the state is IDLE but cache contents are invalid.
    // Force the stall low so the cpu is not held by a spurious miss.
    if (RESET) begin
      BUSYWAIT = 1'b0;
      do_write = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NBLK; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
      fill_q  <= '0;
    end else begin
      if (do_write) begin
        data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
        dirty_q[idx]                     <= 1'b1;
      end
      // Capture the refill on the completing edge.
      // UPDATE then installs it while the cpu request is still held stable.
      if (state == MEM_READ_ST && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
      if (state == UPDATE) begin
        data_q[idx]  <= fill_q;
        tag_q[idx]   <= tag_in;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Testbench for dcache_direct_mapped: a directed vector table, reset-abort and slow-memory sequences,
// then randomized loads/stores checked against an array-based cache/memory model.
// Memory latency is programmable per operation through lat.
module tb_dcache_direct_mapped;

  logic        clk, rst, read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  dcache_direct_mapped dut (
    .CLK(clk), .RESET(rst), .READ(read), .WRITE(write), .ADDRESS(address),
    .WRITEDATA(writedata), .READDATA(readdata), .BUSYWAIT(busywait),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
    .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata), .MEM_BUSYWAIT(mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory seen by the DUT.
  // It stays busy for lat cycles of a request and completes on the next posedge.
  logic [31:0] pmem [64];
  int          lat;
  int          mcnt;
  assign mem_busywait = (mem_read || mem_write) && (mcnt < lat);
  assign mem_readdata = pmem[mem_address];

  always @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 0;
    else if (mem_read || mem_write) begin
      if (mcnt < lat) mcnt <= mcnt + 1;
      else begin
        mcnt <= 0;
        if (mem_write) pmem[mem_address] <= mem_writedata;
      end
    end else mcnt <= 0;
  end

  int both_hi;
  always @(negedge clk) if (mem_read && mem_write) both_hi++;

  int n_checks, n_fail;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: cache arrays plus the model's own copy of memory.
  logic [31:0] mdata [8];
  logic [2:0]  mtag  [8];
  bit          mvalid[8], mdirty[8];
  logic [31:0] mmem  [64];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mdata[i] = '0; mtag[i] = '0; mvalid[i] = 0; mdirty[i] = 0;
    end
  endtask

  task automatic model_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd, input int l,
                          output int st, output logic [7:0] rdv, output logic [5:0] ra,
                          output logic [5:0] wa, output logic [31:0] wdat);
    int idx, off;
    logic [2:0] tg;
    idx = a / 4 % 8; off = a % 4; tg = a[7:5];
    st = 0; ra = '0; wa = '0; wdat = '0;
    if (!(mvalid[idx] && mtag[idx] == tg)) begin
      st = 1 + (l + 1) + 1;
      if (mdirty[idx]) begin
        st  += l + 1;
        wa   = {mtag[idx], 3'(idx)};
        wdat = mdata[idx];
        mmem[wa] = mdata[idx];
      end
      ra = {tg, 3'(idx)};
      mdata[idx] = mmem[ra]; mtag[idx] = tg; mvalid[idx] = 1; mdirty[idx] = 0;
    end
    if (wr) begin
      mdata[idx][off*8 +: 8] = wd;
      mdirty[idx] = 1;
    end
    rdv = mdata[idx][off*8 +: 8];
  endtask

  // Starts just after a negedge and returns just after the negedge following the commit edge.
  task automatic do_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       input logic [5:0] exp_ra, input logic [5:0] exp_wa, input logic [31:0] exp_wd,
                       output int stalls, output logic [7:0] rdata, output bit ok,
                       output logic [5:0] ra_seen, output logic [5:0] wa_seen, output logic [31:0] wd_seen);
    bit seen_rd;
    read = rd; write = wr; address = a; writedata = wd;
    stalls = 0; ok = 1; seen_rd = 0; ra_seen = '1; wa_seen = '1; wd_seen = '1;
    for (int c = 0; c <= 100; c++) begin
      #1;
      if (!busywait) break;
      if (c == 100) begin ok = 0; break; end
      stalls++;
      if (mem_read) begin
        seen_rd = 1; ra_seen = mem_address;
        if (mem_address != exp_ra) ok = 0;
      end
      if (mem_write) begin
        wa_seen = mem_address; wd_seen = mem_writedata;
        if (seen_rd || mem_address != exp_wa || mem_writedata != exp_wd) ok = 0;
      end
      @(negedge clk);
    end
    rdata = readdata;
    @(negedge clk);
    read = 0; write = 0;
  endtask

  typedef struct {
    bit         rd, wr;
    logic [7:0] addr, wd;
    int         stalls;
    bit         chk_rd;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int st, mst;
    logic [7:0] rdv, mrdv;
    logic [5:0] ra, wa, ras, was;
    logic [31:0] wdat, wds;
    bit ok, rr, ww;
    logic [7:0] a, d;

    vecs[0] = '{1, 0, 8'h00, 8'h00, 4, 1, 8'h11};
    vecs[1] = '{1, 0, 8'h03, 8'h00, 0, 1, 8'h44};
    vecs[2] = '{0, 1, 8'h01, 8'hAB, 0, 0, 8'h00};
    vecs[3] = '{1, 0, 8'h01, 8'h00, 0, 1, 8'hAB};
    vecs[4] = '{1, 0, 8'h20, 8'h00, 6, 1, 8'h55};
    vecs[5] = '{0, 1, 8'h1C, 8'h5A, 4, 0, 8'h00};
    vecs[6] = '{1, 0, 8'h1C, 8'h00, 0, 1, 8'h5A};
    vecs[7] = '{1, 0, 8'h01, 8'h00, 4, 1, 8'hAB};

    n_checks = 0; n_fail = 0; both_hi = 0;
    for (int i = 0; i < 64; i++) pmem[i] = $urandom;
    pmem[0] = 32'h44332211;
    pmem[8] = 32'h88776655;
    for (int i = 0; i < 64; i++) mmem[i] = pmem[i];
    model_reset();

    lat = 1; rst = 1; read = 0; write = 0; address = 0; writedata = 0;
    #1;
    chk("rst_busywait", busywait, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    chk("rst_readdata", readdata, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      model_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, lat, mst, mrdv, ra, wa, wdat);
      do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, ra, wa, wdat, st, rdv, ok, ras, was, wds);
      chk($sformatf("vec%0d_stalls", i), st, vecs[i].stalls);
      chk($sformatf("vec%0d_memif", i), ok, 1);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_readdata", i), rdv, vecs[i].rdata);
      if (i == 4) begin
        chk("evict_addr", was, 6'h00);
        chk("evict_data", wds, 32'h4433AB11);
        chk("refill_addr", ras, 6'h08);
      end
      if (i == 5) chk("wmiss_refill_addr", ras, 6'h07);
    end

    // Reset arriving while a refill is outstanding.
    lat = 5;
    read = 1; address = 8'h40;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mem_read) break;
      @(negedge clk);
    end
    chk("abort_reached_memread", mem_read, 1);
    @(negedge clk);
    #1;
    rst = 1; read = 0;
    #1;
    chk("abort_mem_read", mem_read, 0);
    chk("abort_busywait", busywait, 0);
    chk("abort_mem_address", mem_address, 0);
    chk("abort_readdata", readdata, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    lat = 1;
    model_op(1, 0, 8'h01, 8'h00, lat, mst, mrdv, ra, wa, wdat);
    do_op(1, 0, 8'h01, 8'h00, ra, wa, wdat, st, rdv, ok, ras, was, wds);
    chk("post_reset_miss_stalls", st, 4);
    chk("post_reset_readdata", rdv, 8'hAB);

    // Slow memory: the request must stay steady for the whole busy window.
    lat = 5;
    model_op(1, 0, 8'h20, 8'h00, lat, mst, mrdv, ra, wa, wdat);
    do_op(1, 0, 8'h20, 8'h00, ra, wa, wdat, st, rdv, ok, ras, was, wds);
    chk("slow_mem_stalls", st, 8);
    chk("slow_mem_addr_stable", ok, 1);
    chk("slow_mem_readdata", rdv, 8'h55);

    for (int n = 0; n < 300; n++) begin
      lat = $urandom_range(0, 3);
      a = 8'($urandom); d = 8'($urandom);
      ww = ($urandom_range(0, 1) == 1);
      rr = !ww || ($urandom_range(0, 7) == 0);
      model_op(rr, ww, a, d, lat, mst, mrdv, ra, wa, wdat);
      do_op(rr, ww, a, d, ra, wa, wdat, st, rdv, ok, ras, was, wds);
      chk($sformatf("rnd%0d_stalls a=%0h", n, a), st, mst);
      chk($sformatf("rnd%0d_memif a=%0h", n, a), ok, 1);
      if (!ww) chk($sformatf("rnd%0d_readdata a=%0h", n, a), rdv, mrdv);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    chk("mem_read_write_exclusive", both_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
